// File: rtl/cv32e40s_fetch_sequencer.sv
// Fetch sequencer: gates prefetch requests to DEPTH, drops stale responses
// after a branch, and sequences pointer fetches (issue, wait, halt).
// Ports: clk, rst_n; branch_i/branch_addr_i/ptr_access_i from IF control;
//   fetch_* to/from prefetcher; resp_valid_i from bus; fifo_* to/from the
//   instruction FIFO; halted_o is high in HALT.
// Macro CV32E40S_FETCH_POP_CREDIT_EN: credit a same-cycle FIFO pop to capacity.
module cv32e40s_fetch_sequencer #(
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH+1)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  input  logic        ptr_access_i,
  output logic        fetch_valid_o,
  input  logic        fetch_ready_i,
  output logic        fetch_branch_o,
  output logic [31:0] fetch_branch_addr_o,
  output logic        fetch_ptr_access_o,
  input  logic        resp_valid_i,
  output logic        fifo_push_o,
  output logic        fifo_ptr_o,
  output logic        fifo_flush_o,
  input  logic        fifo_pop_i,
  output logic        halted_o
);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_PISS  = 2'd1;
  localparam logic [1:0] S_PWAIT = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  logic [1:0]       r_state, w_state_d;
  logic [CNT_W-1:0] r_out, r_disc, r_occ;
  logic [CNT_W-1:0] w_out_d, w_disc_d, w_occ_d;
  logic [CNT_W-1:0] w_occ_eff;
  logic [CNT_W:0]   w_sum;
  logic             w_cap_ok, w_accept, w_live;
  logic             w_resp, w_pop, w_run;

  // Guards keep counters from wrapping on illegal stimulus.
  assign w_resp = resp_valid_i & (r_out != '0);

`ifdef CV32E40S_FETCH_POP_CREDIT_EN
  assign w_occ_eff = branch_i ? '0 :
    r_occ - CNT_W'(fifo_pop_i & (r_occ != '0));
`else
  assign w_occ_eff = branch_i ? '0 : r_occ;
`endif

  assign w_sum    = {1'b0, r_out} + {1'b0, w_occ_eff};
  assign w_cap_ok = w_sum < (CNT_W+1)'(DEPTH);

  assign w_run = (r_state == S_RUN) | (r_state == S_PISS);

  assign fetch_valid_o = rst_n & (branch_i | w_run) & w_cap_ok;
  assign w_accept      = fetch_valid_o & fetch_ready_i;

  assign fetch_branch_o      = branch_i;
  assign fetch_branch_addr_o = branch_addr_i;
  assign fetch_ptr_access_o  = branch_i & ptr_access_i;
  assign fifo_flush_o        = branch_i;

  assign w_live      = resp_valid_i & (r_disc == '0) & ~branch_i;
  assign fifo_push_o = w_live;
  assign fifo_ptr_o  = w_live & (r_state == S_PWAIT);
  assign halted_o    = (r_state == S_HALT);

  always_comb begin
    w_state_d = r_state;
    if (branch_i) begin
      if (ptr_access_i)
        w_state_d = w_accept ? S_PWAIT : S_PISS;
      else
        w_state_d = S_RUN;
    end else begin
      unique case (1'b1)
        (r_state == S_PISS):  if (w_accept) w_state_d = S_PWAIT;
        (r_state == S_PWAIT): if (w_live) w_state_d = S_HALT;
        default: ;
      endcase
    end
  end

  assign w_pop = fifo_pop_i & ((r_occ != '0) | w_live);

  always_comb begin
    w_out_d  = r_out + CNT_W'(w_accept) - CNT_W'(w_resp);
    w_disc_d = r_disc;
    w_occ_d  = r_occ + CNT_W'(w_live) - CNT_W'(w_pop);
    if (branch_i) begin
      // Every older in-flight transaction is still owed a response.
      w_disc_d = r_out - CNT_W'(w_resp);
      w_occ_d  = '0;
    end else if (resp_valid_i && r_disc != '0) begin
      w_disc_d = r_disc - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RUN;
      r_out   <= '0;
      r_disc  <= '0;
      r_occ   <= '0;
    end else begin
      r_state <= w_state_d;
      r_out   <= w_out_d;
      r_disc  <= w_disc_d;
      r_occ   <= w_occ_d;
    end
  end

endmodule

// File: tb/tb_cv32e40s_fetch_sequencer.sv
// Bench for cv32e40s_fetch_sequencer: directed scenarios plus random traffic,
// with a response scoreboard tracking which accepts are still live.
module tb_cv32e40s_fetch_sequencer;

  logic        clk = 0;
  logic        rst_n;
  logic        branch_i;
  logic [31:0] branch_addr_i;
  logic        ptr_access_i;
  logic        fetch_valid_o;
  logic        fetch_ready_i;
  logic        fetch_branch_o;
  logic [31:0] fetch_branch_addr_o;
  logic        fetch_ptr_access_o;
  logic        resp_valid_i;
  logic        fifo_push_o;
  logic        fifo_ptr_o;
  logic        fifo_flush_o;
  logic        fifo_pop_i;
  logic        halted_o;

  int n_pass = 0;
  int n_total = 0;
  bit sb[$];

`ifdef CV32E40S_FETCH_POP_CREDIT_EN
  localparam bit CREDIT = 1'b1;
`else
  localparam bit CREDIT = 1'b0;
`endif

  cv32e40s_fetch_sequencer #(.DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .branch_i(branch_i), .branch_addr_i(branch_addr_i),
    .ptr_access_i(ptr_access_i),
    .fetch_valid_o(fetch_valid_o), .fetch_ready_i(fetch_ready_i),
    .fetch_branch_o(fetch_branch_o),
    .fetch_branch_addr_o(fetch_branch_addr_o),
    .fetch_ptr_access_o(fetch_ptr_access_o),
    .resp_valid_i(resp_valid_i),
    .fifo_push_o(fifo_push_o), .fifo_ptr_o(fifo_ptr_o),
    .fifo_flush_o(fifo_flush_o), .fifo_pop_i(fifo_pop_i),
    .halted_o(halted_o)
  );

  always #5 clk = ~clk;

  // Illegal stimulus monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      if (resp_valid_i && dut.r_out == '0) begin
        n_total++;
        $display("FAIL illegal_resp: resp with 0 outstanding");
      end
      if (fifo_pop_i && dut.r_occ == '0 && !fifo_push_o) begin
        n_total++;
        $display("FAIL illegal_pop: pop with empty fifo");
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit br, input logic [31:0] a,
                        input bit p, input bit rdy,
                        input bit rsp, input bit pop);
    branch_i = br; branch_addr_i = a; ptr_access_i = p;
    fetch_ready_i = rdy; resp_valid_i = rsp; fifo_pop_i = pop;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    set_in(0, 0, 0, 0, 0, 0);
    n_total++;
    if (fetch_valid_o !== 1'b0)
      $display("FAIL rst_valid: got %b want 0", fetch_valid_o);
    else n_pass++;
    n_total++;
    if (halted_o !== 1'b0 || fifo_push_o !== 1'b0)
      $display("FAIL rst_out: halted %b push %b want 0 0",
               halted_o, fifo_push_o);
    else n_pass++;
    tick();
    rst_n = 1;
    #1;
    n_total++;
    if (fetch_valid_o !== 1'b1)
      $display("FAIL rst_release_valid: got %b want 1", fetch_valid_o);
    else n_pass++;
  endtask

  task automatic test_fill();
    bit exp_v[4] = '{1, 1, 0, 0};
    for (int c = 0; c < 4; c++) begin
      set_in(0, 0, 0, 1, 0, 0);
      n_total++;
      if (fetch_valid_o !== exp_v[c])
        $display("FAIL fill_valid c%0d: got %b want %b",
                 c, fetch_valid_o, exp_v[c]);
      else n_pass++;
      if (exp_v[c]) sb.push_back(1'b1);
      tick();
    end
  endtask

  task automatic test_branch_drop();
    bit e;
    set_in(1, 32'h100, 0, 0, 1, 0);
    e = sb.pop_front();
    foreach (sb[i]) sb[i] = 1'b0;
    n_total++;
    if (fifo_push_o !== (e & 1'b0) || fifo_flush_o !== 1'b1)
      $display("FAIL br_drop: push %b flush %b want 0 1",
               fifo_push_o, fifo_flush_o);
    else n_pass++;
    n_total++;
    if (fetch_branch_addr_o !== 32'h100 || fetch_branch_o !== 1'b1)
      $display("FAIL br_addr: got %h want 00000100", fetch_branch_addr_o);
    else n_pass++;
    n_total++;
    if (fetch_valid_o !== 1'b0)
      $display("FAIL br_valid: got %b want 0", fetch_valid_o);
    else n_pass++;
    tick();
    set_in(0, 0, 0, 0, 1, 0);
    e = sb.pop_front();
    n_total++;
    if (fifo_push_o !== e)
      $display("FAIL discard_resp: push %b want %b", fifo_push_o, e);
    else n_pass++;
    tick();
    set_in(0, 0, 0, 1, 0, 0);
    n_total++;
    if (fetch_valid_o !== 1'b1)
      $display("FAIL refetch_valid: got %b want 1", fetch_valid_o);
    else n_pass++;
    sb.push_back(1'b1);
    tick();
    set_in(0, 0, 0, 0, 1, 0);
    e = sb.pop_front();
    n_total++;
    if (fifo_push_o !== e || fifo_ptr_o !== 1'b0)
      $display("FAIL live_resp: push %b ptr %b want %b 0",
               fifo_push_o, fifo_ptr_o, e);
    else n_pass++;
    tick();
    set_in(0, 0, 0, 0, 0, 1);
    tick();
  endtask

  task automatic test_ptr();
    bit e;
    set_in(1, 32'h40, 1, 0, 0, 0);
    n_total++;
    if (fetch_valid_o !== 1'b1 || fetch_ptr_access_o !== 1'b1)
      $display("FAIL ptr_br: valid %b ptr %b want 1 1",
               fetch_valid_o, fetch_ptr_access_o);
    else n_pass++;
    tick();
    for (int c = 0; c < 2; c++) begin
      set_in(0, 0, 0, 0, 0, 0);
      n_total++;
      if (fetch_valid_o !== 1'b1 || halted_o !== 1'b0)
        $display("FAIL ptr_issue c%0d: valid %b halted %b want 1 0",
                 c, fetch_valid_o, halted_o);
      else n_pass++;
      tick();
    end
    set_in(0, 0, 0, 1, 0, 0);
    n_total++;
    if (fetch_valid_o !== 1'b1)
      $display("FAIL ptr_accept: got %b want 1", fetch_valid_o);
    else n_pass++;
    sb.push_back(1'b1);
    tick();
    set_in(0, 0, 0, 1, 0, 0);
    n_total++;
    if (fetch_valid_o !== 1'b0)
      $display("FAIL ptr_wait_valid: got %b want 0", fetch_valid_o);
    else n_pass++;
    tick();
    set_in(0, 0, 0, 0, 1, 0);
    e = sb.pop_front();
    n_total++;
    if (fifo_push_o !== e || fifo_ptr_o !== 1'b1)
      $display("FAIL ptr_resp: push %b ptr %b want %b 1",
               fifo_push_o, fifo_ptr_o, e);
    else n_pass++;
    tick();
    set_in(0, 0, 0, 1, 0, 0);
    n_total++;
    if (halted_o !== 1'b1 || fetch_valid_o !== 1'b0)
      $display("FAIL halt: halted %b valid %b want 1 0",
               halted_o, fetch_valid_o);
    else n_pass++;
    tick();
  endtask

  task automatic test_halt_branch();
    set_in(1, 32'h2000, 0, 0, 0, 0);
    n_total++;
    if (fetch_valid_o !== 1'b1 || fetch_branch_addr_o !== 32'h2000)
      $display("FAIL halt_br: valid %b addr %h want 1 00002000",
               fetch_valid_o, fetch_branch_addr_o);
    else n_pass++;
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    n_total++;
    if (halted_o !== 1'b0 || fetch_valid_o !== 1'b1)
      $display("FAIL halt_exit: halted %b valid %b want 0 1",
               halted_o, fetch_valid_o);
    else n_pass++;
    tick();
  endtask

  task automatic test_full();
    bit e;
    for (int c = 0; c < 2; c++) begin
      set_in(0, 0, 0, 1, 0, 0);
      sb.push_back(1'b1);
      tick();
    end
    for (int c = 0; c < 2; c++) begin
      set_in(0, 0, 0, 0, 1, 0);
      e = sb.pop_front();
      n_total++;
      if (fifo_push_o !== e)
        $display("FAIL full_resp c%0d: push %b want %b", c, fifo_push_o, e);
      else n_pass++;
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0);
    n_total++;
    if (fetch_valid_o !== 1'b0)
      $display("FAIL full_valid: got %b want 0", fetch_valid_o);
    else n_pass++;
    tick();
    set_in(0, 0, 0, 0, 0, 1);
    n_total++;
    if (fetch_valid_o !== CREDIT)
      $display("FAIL pop_credit: got %b want %b", fetch_valid_o, CREDIT);
    else n_pass++;
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    n_total++;
    if (fetch_valid_o !== 1'b1)
      $display("FAIL pop_next: got %b want 1", fetch_valid_o);
    else n_pass++;
    tick();
    set_in(0, 0, 0, 0, 0, 1);
    tick();
  endtask

  task automatic test_random();
    int m_out = 0;
    int m_occ = 0;
    for (int c = 0; c < 10000; c++) begin
      bit br, rdy, rsp, pop, e, ev, epush;
      int eff;
      br  = ($urandom_range(15) == 0);
      rdy = $urandom_range(1);
      rsp = (m_out > 0) && ($urandom_range(2) != 0);
      pop = (m_occ > 0) && ($urandom_range(1) != 0);
      set_in(br, $urandom & 32'hFFFF_FFFC, 0, rdy, rsp, pop);
      eff = br ? 0 : m_occ - (CREDIT ? int'(pop) : 0);
      ev  = (m_out + eff) < 2;
      n_total++;
      if (fetch_valid_o !== ev || fifo_flush_o !== br)
        $display("FAIL rnd_valid c%0d: valid %b flush %b want %b %b",
                 c, fetch_valid_o, fifo_flush_o, ev, br);
      else n_pass++;
      epush = 1'b0;
      if (rsp) begin
        e = sb.pop_front();
        epush = e & ~br;
      end
      n_total++;
      if (fifo_push_o !== epush || fifo_ptr_o !== 1'b0)
        $display("FAIL rnd_push c%0d: push %b ptr %b want %b 0",
                 c, fifo_push_o, fifo_ptr_o, epush);
      else n_pass++;
      if (br) foreach (sb[i]) sb[i] = 1'b0;
      if (ev && rdy) sb.push_back(1'b1);
      m_out = m_out + int'(ev && rdy) - int'(rsp);
      m_occ = br ? 0 : m_occ + int'(epush) - int'(pop);
      tick();
    end
  endtask

  initial begin
    rst_n = 0;
    set_in(0, 0, 0, 0, 0, 0);
    tick();
    test_reset();
    test_fill();
    test_branch_drop();
    test_ptr();
    test_halt_branch();
    test_full();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cv32e40s_fetch_sequencer.md
Name: cv32e40s_fetch_sequencer

Overview:
- Sequences the prefetcher for the instruction-fetch path.
- Decides when a new transaction request may be raised, which bounds outstanding transactions plus buffered responses to DEPTH.
- Tracks in-flight transactions and discards stale responses after a branch or flush.
- Sequences CLIC/Zc pointer fetches: one pointer access, wait for its response, then halt until the next branch.
- Sits between the IF-stage branch/consumer logic, the prefetcher (valid/ready and branch interface) and the instruction response FIFO.

Parameters:
- DEPTH, 2, maximum sum of outstanding transactions and FIFO occupancy (legal range 1..4).
- CNT_W, $clog2(DEPTH+1), derived width of every internal counter; not overridable.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- branch_i  input  1  taken branch/flush request from IF control.
- branch_addr_i  input  32  branch target, word aligned; valid only when branch_i=1.
- ptr_access_i  input  1  branch target is a pointer (data) fetch; qualified by branch_i.
- fetch_valid_o  output  1  request valid to prefetcher.
- fetch_ready_i  input  1  prefetcher accepted request (transaction issued).
- fetch_branch_o  output  1  branch indication to prefetcher.
- fetch_branch_addr_o  output  32  branch address to prefetcher.
- fetch_ptr_access_o  output  1  pointer-access flag to prefetcher.
- resp_valid_i  input  1  bus response for oldest outstanding transaction.
- fifo_push_o  output  1  write response into instruction FIFO.
- fifo_ptr_o  output  1  pushed entry is a pointer response.
- fifo_flush_o  output  1  clear instruction FIFO.
- fifo_pop_i  input  1  consumer removed one FIFO entry.
- halted_o  output  1  sequencer in HALT state.

Behaviour:
- Reset values:
  - state=RUN; outstanding_q, discard_q and occ_q all 0.
  - All outputs 0 during reset, except fetch_valid_o=1 once rst_n deasserts, because capacity is 0<DEPTH in RUN.
- Passthrough:
  - fetch_branch_o=branch_i.
  - fetch_branch_addr_o=branch_addr_i.
  - fetch_ptr_access_o=branch_i & ptr_access_i.
  - fifo_flush_o=branch_i.
- Capacity: cap_ok = (outstanding_q + occ_eff) < DEPTH.
  - occ_eff = 0 when branch_i=1, otherwise occ_q.
  - Same-cycle fifo_pop_i is not credited (see Optional Feature).
- fetch_valid_o by state:
  - RUN: cap_ok.
  - PTR_ISSUE: cap_ok.
  - PTR_WAIT: 0 unless branch_i.
  - HALT: 0 unless branch_i.
  - branch_i in any state: fetch_valid_o=cap_ok.
- accept = fetch_valid_o & fetch_ready_i.
- Next state when branch_i=1 (branch has priority over all other events):
  - ptr_access_i=1: PTR_WAIT if accept, else PTR_ISSUE.
  - ptr_access_i=0: RUN.
- Next state when branch_i=0:
  - RUN: stays RUN.
  - PTR_ISSUE: goes to PTR_WAIT on accept.
  - PTR_WAIT: goes to HALT on fifo_push_o.
  - HALT: stays until branch_i.
- Response handling:
  - live = resp_valid_i & (discard_q==0) & ~branch_i.
  - fifo_push_o=live.
  - fifo_ptr_o = live & (state==PTR_WAIT).
  - Responses arriving on a branch cycle or while discard_q>0 are dropped. discard_q decrements on each such drop when it is nonzero.
- Counter updates:
  - outstanding_d = outstanding_q + accept - resp_valid_i. Simultaneous accept and response leaves it unchanged.
  - On branch_i: discard_d = outstanding_q - resp_valid_i, i.e. all older in-flight transactions are still owed.
  - occ_d = 0 on branch_i, else occ_q + fifo_push_o - fifo_pop_i.
- Invariant: outstanding_q + occ_q <= DEPTH at all times. Counters never wrap.
- Illegal stimulus, to be flagged by bench assertions:
  - resp_valid_i with outstanding_q==0.
  - fifo_pop_i with occ_q==0 and no push.
- Prefetcher holds a branch address across stalls, so a branch with fetch_ready_i=0 needs no address storage here.
- halted_o = (state==HALT), registered from state.
- Reset mid-operation: all counters and state clear asynchronously; responses pending on the bus after reset are the system's responsibility.

Optional Feature:
- Macro: CV32E40S_FETCH_POP_CREDIT_EN.
- Defined: occ_eff = occ_q - fifo_pop_i (when branch_i=0), so a same-cycle pop frees capacity immediately. This gives back-to-back issue at full FIFO.
- Undefined: pop credited the following cycle, giving one bubble when full.
- Invariant holds in both builds.

Test Plan:
- DEPTH=2, reset release, fetch_ready_i=1, no responses -> two accepts on cycles 0 and 1. fetch_valid_o=0 from cycle 2. outstanding_q=2.
- outstanding_q=2, occ_q=0, branch_i=1 with addr 0x100 and resp_valid_i=1 the same cycle -> response dropped (fifo_push_o=0), fifo_flush_o=1, discard_d=1. The next response is dropped, the one after is pushed.
- branch_i=1 with ptr_access_i=1 and fetch_ready_i=0 for 3 cycles -> state PTR_ISSUE with fetch_valid_o=1. On accept -> PTR_WAIT. The response is pushed with fifo_ptr_o=1, then HALT with halted_o=1 and fetch_valid_o=0.
- HALT, then branch_i=1 with addr 0x2000 and ptr_access_i=0 -> fetch_valid_o=1 the same cycle, state RUN.
- FIFO full (occ_q=2), fifo_pop_i=1 -> fetch_valid_o=1 the same cycle with CV32E40S_FETCH_POP_CREDIT_EN defined, or one cycle later without it.
- Random accept/response/pop/branch for 10k cycles -> no wrap, invariant holds, and every pushed response belongs to the latest branch epoch.
